insn_decode_stage: RTL and testbench
====================================

# insn_decode_stage

Registered, parametrised instruction-decode pipeline stage with valid/ready handshakes on both sides, a per-register reservation scoreboard, and a mode-dependent immediate extender. It sits between instruction fetch and the execute/register-read stage. It replaces the purely combinational decode path with a one-entry pipeline register. Read-after-write and write-after-write hazards are resolved here by stalling fetch.

## Interface
Parameters:
- LEN_INSN, 32: instruction width
- LEN_OPECODE, 7: opcode field width
- SHIFT_OPECODE, 25: opcode LSB position
- SHIFT_IMMF, 24: 1-bit immediate-flag position
- LEN_REGNO, 4: register-number width; the register count is 2**LEN_REGNO
- SHIFT_RD, 20 / SHIFT_RS, 16: rd and rs LSB positions
- LEN_CC, 4 / SHIFT_CC, 16: condition-code field
- LEN_IMM, 16 / SHIFT_IMM, 0: raw immediate field
- LEN_IMM_EX, 32: extended immediate width; must be ≥ LEN_IMM

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous pipeline flush
- in_valid_i  in  1  fetch presents insn_i
- in_ready_o  out  1  stage accepts insn_i this cycle
- insn_i  in  LEN_INSN  instruction word
- out_valid_o  out  1  decoded fields valid
- out_ready_i  in  1  downstream consumes the decoded fields
- opecode_o  out  LEN_OPECODE  raw opcode
- writes_o  out  1  instruction writes rd (opcode ≠ 0)
- immf_o  out  1  immediate flag
- rd_o, rs_o  out  LEN_REGNO  register numbers
- cc_o  out  LEN_CC  condition code
- imm_o  out  LEN_IMM_EX  extended immediate
- wb_valid_i  in  1  writeback retires a register
- wb_r_i  in  LEN_REGNO  register being retired

## Operation
- Accept occurs when in_valid_i && in_ready_o. On accept, all fields are decoded and captured into the output register, and out_valid_o is set to 1.
- Consume occurs when out_valid_o && out_ready_i. If there is a consume and no accept in the same cycle, out_valid_o is cleared to 0.
- writes_o is 1 when the opcode is nonzero; opcode 0 is NOP.
- Immediate extension (when immf = 1). The pattern is matched against the opcode:
  - 000_0xxx: sign-extend imm
  - 000_1xxx: zero-extend imm[4:0] (shift amount)
  - 001_1xxx: sign-extend imm
  - all others: zero-extend imm
- When immf = 0, imm_o = 0. The result is always defined, never X.
- Scoreboard: one reserved bit per register.
  - A bit is set on an accept with writes = 1, indexed by rd.
  - A bit is cleared by wb_valid_i, indexed by wb_r_i.
- Effective reservation = reserved & ~(wb_valid_i one-hot of wb_r_i). A same-cycle writeback therefore bypasses the hazard.
- Hazard exists when either of these holds:
  - the effective reservation of rd is set;
  - immf = 0 and the effective reservation of rs is set.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i.
- Same-cycle accept with writes = 1 and writeback to the same register: the set wins, so the bit ends at 1.
- flush_i clears out_valid_o and every reserved bit, and forces in_ready_o to 0. flush_i has priority over accept and writeback.

## Timing
- Latency from accept to out_valid_o is 1 cycle. Full throughput is one instruction per cycle when there are no hazards.
- in_ready_o is combinational from out_valid_o, out_ready_i, the scoreboard, insn_i, wb_*, and flush_i. There is no combinational path from in_valid_i to in_ready_o.
- Decoded outputs hold stable while out_valid_o && !out_ready_i.
- Reset: out_valid_o = 0 and all reserved bits = 0. opecode_o, writes_o, immf_o, rd_o, rs_o, cc_o, and imm_o are all 0.
- Reset asserted mid-stall drops the held instruction. Fetch must re-present it.
- A back-to-back dependent pair (rd of the first equals rs of the second) stalls until wb_valid_i for that register. The second instruction is accepted in the same cycle as the writeback.

## Configuration
- INSN_DECODE_SCOREBOARD_EN defined: the scoreboard and hazard stall are present as described above.
- Not defined: no reserved bits exist and hazard = 0. wb_valid_i and wb_r_i are ignored. in_ready_o = (!out_valid_o || out_ready_i) && !flush_i. Hazard resolution becomes the responsibility of downstream logic.

## Test plan
- Reset, then stream 4 independent insns with out_ready_i = 1 -> one accepted per cycle; out_valid_o first rises 1 cycle after the first accept.
- Opcode 000_0001, immf = 1, imm = 0x8000 -> imm_o = 0xFFFF8000. Opcode 000_1000, imm = 0xFFFF -> imm_o = 0x0000001F. Opcode 010_0000, imm = 0x8000 -> imm_o = 0x00008000. immf = 0 -> imm_o = 0.
- Write r3, then insn reading rs = r3 with immf = 0 -> in_ready_o = 0 until wb_valid_i with wb_r_i = 3. Accept occurs in that same cycle.
- out_ready_i held at 0 for 3 cycles with out_valid_o = 1 -> outputs unchanged and in_ready_o = 0. Releasing out_ready_i allows the next accept in the same cycle.
- Accept writing r5 together with wb_r_i = 5 in the same cycle -> r5 remains reserved, and the next insn using r5 stalls.
- flush_i with out_valid_o = 1 and r2 reserved -> next cycle out_valid_o = 0 and an insn using r2 is accepted immediately.

Source files
------------

// File: rtl/insn_decode_stage.sv
// insn_decode_stage: registered instruction decode with valid/ready handshakes and immediate extension.
// The register-reservation scoreboard and hazard stall exist only when INSN_DECODE_SCOREBOARD_EN is defined.
module insn_decode_stage #(
    parameter int LEN_INSN      = 32,
    parameter int LEN_OPECODE   = 7,
    parameter int SHIFT_OPECODE = 25,
    parameter int SHIFT_IMMF    = 24,
    parameter int LEN_REGNO     = 4,
    parameter int SHIFT_RD      = 20,
    parameter int SHIFT_RS      = 16,
    parameter int LEN_CC        = 4,
    parameter int SHIFT_CC      = 16,
    parameter int LEN_IMM       = 16,
    parameter int SHIFT_IMM     = 0,
    parameter int LEN_IMM_EX    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LEN_INSN-1:0]    insn_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LEN_OPECODE-1:0] opecode_o,
    output logic                   writes_o,
    output logic                   immf_o,
    output logic [LEN_REGNO-1:0]   rd_o,
    output logic [LEN_REGNO-1:0]   rs_o,
    output logic [LEN_CC-1:0]      cc_o,
    output logic [LEN_IMM_EX-1:0]  imm_o,
    input  logic                   wb_valid_i,
    input  logic [LEN_REGNO-1:0]   wb_r_i
);
    localparam int NREG = 2**LEN_REGNO;

    logic [LEN_OPECODE-1:0]       opc;
    logic                         immf, writes, hazard, accept;
    logic [LEN_REGNO-1:0]         rd, rs;
    logic [LEN_CC-1:0]            cc;
    logic [LEN_IMM-1:0]           imm;
    logic [3:0]                   top;
    logic signed [LEN_IMM_EX-1:0] sext;
    logic [LEN_IMM_EX-1:0]        zext, shamt, imm_ex;

    assign opc    = insn_i[SHIFT_OPECODE +: LEN_OPECODE];
    assign immf   = insn_i[SHIFT_IMMF];
    assign rd     = insn_i[SHIFT_RD +: LEN_REGNO];
    assign rs     = insn_i[SHIFT_RS +: LEN_REGNO];
    assign cc     = insn_i[SHIFT_CC +: LEN_CC];
    assign imm    = insn_i[SHIFT_IMM +: LEN_IMM];
    assign writes = |opc;
    assign top    = opc[LEN_OPECODE-1 -: 4];
    assign sext   = $signed(imm);
    assign zext   = LEN_IMM_EX'(imm);
    assign shamt  = LEN_IMM_EX'(imm[4:0]);

    // Extension mode follows the upper four opcode bits; no immediate means a zero result
    always_comb begin
        imm_ex = '0;
        if (immf)
            imm_ex = (top == 4'b0000 || top == 4'b0011) ? sext : (top == 4'b0001) ? shamt : zext;
    end

`ifdef INSN_DECODE_SCOREBOARD_EN
    logic [NREG-1:0] reserved, wb_mask, eff;

    assign wb_mask = wb_valid_i ? (NREG'(1) << wb_r_i) : '0;
    assign eff     = reserved & ~wb_mask;
    assign hazard  = eff[rd] || (!immf && eff[rs]);

    // Reservations: flush clears all, a same-cycle retire is applied first so a new write reservation wins
    always_ff @(posedge clk) begin
        if (rst || flush_i)
            reserved <= '0;
        else
            reserved <= eff | ((accept && writes) ? (NREG'(1) << rd) : '0);
    end
`else
    logic unused_wb;

    assign unused_wb = ^{wb_valid_i, wb_r_i};
    assign hazard    = 1'b0;
`endif

    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Output register: capture on accept, drop valid on consume or flush
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            opecode_o   <= '0;
            writes_o    <= 1'b0;
            immf_o      <= 1'b0;
            rd_o        <= '0;
            rs_o        <= '0;
            cc_o        <= '0;
            imm_o       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            opecode_o   <= opc;
            writes_o    <= writes;
            immf_o      <= immf;
            rd_o        <= rd;
            rs_o        <= rs;
            cc_o        <= cc;
            imm_o       <= imm_ex;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_insn_decode_stage.sv
// tb_insn_decode_stage: directed and random checks of insn_decode_stage against a behavioural model
module tb_insn_decode_stage;
`ifdef INSN_DECODE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush_i, in_valid_i, out_ready_i, wb_valid_i;
    logic [31:0] insn_i;
    logic [3:0]  wb_r_i;
    logic        in_ready_o, out_valid_o, writes_o, immf_o;
    logic [6:0]  opecode_o;
    logic [3:0]  rd_o, rs_o, cc_o;
    logic [31:0] imm_o;

    int vectors = 0;
    int miscompares = 0;

    bit          res[16];
    bit          m_valid, m_writes, m_immf;
    int unsigned m_opc, m_rd, m_rs, m_cc, m_imm;

    insn_decode_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .insn_i(insn_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .opecode_o(opecode_o), .writes_o(writes_o), .immf_o(immf_o),
        .rd_o(rd_o), .rs_o(rs_o), .cc_o(cc_o), .imm_o(imm_o),
        .wb_valid_i(wb_valid_i), .wb_r_i(wb_r_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(int unsigned opc, int unsigned immf, int unsigned rd,
                                       int unsigned rs, int unsigned imm);
        return opc * 32'h0200_0000 + immf * 32'h0100_0000 + rd * 32'h0010_0000
             + rs * 32'h0001_0000 + (imm % 65536);
    endfunction

    function automatic int unsigned ext(int unsigned opc, int unsigned immf, int unsigned imm);
        if (immf == 0) return 0;
        if (opc < 8 || (opc >= 24 && opc < 32)) return (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
        if (opc < 16) return imm % 32;
        return imm;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_writes = 0; m_immf = 0;
        m_opc = 0; m_rd = 0; m_rs = 0; m_cc = 0; m_imm = 0;
        foreach (res[r]) res[r] = 0;
    endtask

    task automatic cycle();
        int unsigned opc, immf, rd, rs, imm;
        bit eff[16];
        bit hazard, ready;
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            opc  = insn_i / 32'h0200_0000;
            immf = (insn_i / 32'h0100_0000) % 2;
            rd   = (insn_i / 32'h0010_0000) % 16;
            rs   = (insn_i / 32'h0001_0000) % 16;
            imm  = insn_i % 65536;
            foreach (eff[r]) eff[r] = res[r] && !(wb_valid_i && wb_r_i == r);
            hazard = SB && (eff[rd] || (immf == 0 && eff[rs]));
            ready  = (!m_valid || out_ready_i) && !hazard && !flush_i;
            chk("in_ready", in_ready_o, ready);
            chk("out_valid", out_valid_o, m_valid);
            chk("opecode", opecode_o, m_opc);
            chk("writes", writes_o, m_writes);
            chk("immf", immf_o, m_immf);
            chk("rd", rd_o, m_rd);
            chk("rs", rs_o, m_rs);
            chk("cc", cc_o, m_cc);
            chk("imm", imm_o, m_imm);
            if (flush_i) begin
                m_valid = 0;
                foreach (res[r]) res[r] = 0;
            end else begin
                foreach (res[r]) res[r] = eff[r];
                if (in_valid_i && ready) begin
                    if (opc != 0) res[rd] = 1;
                    m_valid = 1; m_opc = opc; m_writes = (opc != 0); m_immf = immf[0];
                    m_rd = rd; m_rs = rs; m_cc = rs; m_imm = ext(opc, immf, imm);
                end else if (m_valid && out_ready_i) begin
                    m_valid = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] insn);
        insn_i = insn;
        in_valid_i = 1'b1;
    endtask

    task automatic retire(input int unsigned r);
        in_valid_i = 1'b0; wb_valid_i = 1'b1; wb_r_i = 4'(r);
        cycle();
        wb_valid_i = 1'b0;
    endtask

    int unsigned opcs[10] = '{0, 1, 7, 8, 15, 24, 31, 32, 64, 127};

    initial begin
        model_reset();
        rst = 1; flush_i = 0; in_valid_i = 0; out_ready_i = 1; wb_valid_i = 0; wb_r_i = 0; insn_i = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 0;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_opc", opecode_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_rd", rd_o, 0);
        #1 chk("rst_ready", in_ready_o, 1);
        cycle();

        // Four independent instructions streamed back to back
        present(mk(1, 1, 6, 0, 16'h8000));
        cycle();
        chk("lat_valid", out_valid_o, 1);
        chk("imm_sext", imm_o, 32'hFFFF_8000);
        present(mk(8, 1, 7, 0, 16'hFFFF));
        #1 chk("tput_ready", in_ready_o, 1);
        cycle();
        chk("imm_shamt", imm_o, 32'h0000_001F);
        present(mk(32, 1, 8, 0, 16'h8000));
        cycle();
        chk("imm_zext", imm_o, 32'h0000_8000);
        present(mk(16, 0, 9, 0, 16'hABCD));
        cycle();
        chk("imm_none", imm_o, 32'h0);
        chk("stream_valid", out_valid_o, 1);
        in_valid_i = 0;
        cycle();
        for (int r = 6; r <= 9; r++) retire(r);

        // Read-after-write on r3 released by a same-cycle writeback
        present(mk(2, 1, 3, 0, 16'h10));
        cycle();
        present(mk(3, 0, 11, 3, 0));
        #1 chk("raw_stall", in_ready_o, !SB);
        for (int i = 0; i < 3; i++) cycle();
        wb_valid_i = 1; wb_r_i = 3;
        #1 chk("raw_bypass", in_ready_o, 1);
        cycle();
        wb_valid_i = 0;
        retire(11);

        // Downstream back-pressure holds the output register
        in_valid_i = 0; out_ready_i = 1;
        cycle();
        present(mk(0, 1, 0, 0, 16'h1234));
        out_ready_i = 0;
        cycle();
        present(mk(64, 1, 12, 0, 16'h55));
        #1 chk("bp_stall", in_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_imm", imm_o, 32'h1234);
            chk("bp_hold_valid", out_valid_o, 1);
        end
        out_ready_i = 1;
        #1 chk("bp_release", in_ready_o, 1);
        cycle();
        chk("bp_next", imm_o, 32'h55);
        retire(12);

        // Write reservation wins over a same-cycle retire of the same register
        present(mk(5, 1, 5, 0, 0));
        wb_valid_i = 1; wb_r_i = 5;
        cycle();
        wb_valid_i = 0;
        present(mk(1, 0, 13, 5, 0));
        #1 chk("setwin_stall", in_ready_o, !SB);
        cycle();
        in_valid_i = 0;
        cycle();

        // Flush drops the held instruction and all reservations
        present(mk(6, 1, 2, 0, 7));
        out_ready_i = 0;
        cycle();
        chk("fl_pre_valid", out_valid_o, 1);
        in_valid_i = 0; flush_i = 1;
        #1 chk("fl_ready", in_ready_o, 0);
        cycle();
        flush_i = 0;
        chk("fl_valid", out_valid_o, 0);
        present(mk(1, 0, 14, 2, 0));
        out_ready_i = 1;
        #1 chk("fl_r2_free", in_ready_o, 1);
        cycle();
        present(mk(1, 0, 15, 5, 0));
        #1 chk("fl_r5_free", in_ready_o, 1);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            wb_valid_i  = ($urandom_range(0, 1) == 0);
            wb_r_i      = 4'($urandom_range(0, 15));
            insn_i      = mk(($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : opcs[$urandom_range(0, 9)],
                             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                             $urandom_range(0, 65535));
            cycle();
        end
        rst = 0; flush_i = 0; in_valid_i = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
